// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and branch types.
// Optional return-address stack when BP_RAS_EN is defined.
module branch_predictor #(
  parameter int N_ENTRIES = 16,
  parameter int CTR_BITS  = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  input  logic        lookup_fire,
  output logic        predict_hit,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic [1:0]  update_type,
  input  logic        flush
);
  localparam int IDX_BITS = $clog2(N_ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(2 ** (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);
  localparam logic [1:0] T_COND = 2'd0;
  localparam logic [1:0] T_CALL = 2'd2;
  localparam logic [1:0] T_RET  = 2'd3;

  logic [N_ENTRIES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q  [N_ENTRIES];
  logic [31:0]          tgt_q  [N_ENTRIES];
  logic [1:0]           type_q [N_ENTRIES];
  logic [CTR_BITS-1:0]  ctr_q  [N_ENTRIES];

  // Lookup side
  logic [IDX_BITS-1:0] l_idx;
  logic [TAG_BITS-1:0] l_tag;
  logic [1:0]          l_type;
  logic [31:0]         seq_pc;

  assign l_idx  = lookup_pc[IDX_BITS+1:2];
  assign l_tag  = lookup_pc[31:IDX_BITS+2];
  assign l_type = type_q[l_idx];
  assign seq_pc = lookup_pc + 32'd4;

  assign predict_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign predict_taken = predict_hit && ((l_type != T_COND) || ctr_q[l_idx][CTR_BITS-1]);

`ifdef BP_RAS_EN
  localparam int RP_BITS = $clog2(RAS_DEPTH);
  localparam logic [RP_BITS:0] RAS_FULL = (RP_BITS+1)'(RAS_DEPTH);

  logic [31:0]        ras_q [RAS_DEPTH];
  logic [RP_BITS-1:0] ras_ptr, ras_nxt;
  logic [RP_BITS:0]   ras_cnt;
  logic               ras_push, ras_pop, ras_use;

  assign ras_nxt  = ras_ptr + 1'b1;
  assign ras_use  = predict_hit && (l_type == T_RET) && (ras_cnt != '0);
  assign ras_push = lookup_fire && predict_hit && (l_type == T_CALL);
  assign ras_pop  = lookup_fire && ras_use;

  assign predict_target = ras_use       ? ras_q[ras_ptr] :
                          predict_taken ? tgt_q[l_idx]   : seq_pc;

  // Pointer always names the top; a push when full silently overwrites the oldest slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (flush) begin
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr        <= ras_nxt;
      ras_q[ras_nxt] <= seq_pc;
      if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
    end else if (ras_pop) begin
      ras_ptr <= ras_ptr - 1'b1;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  logic bp_unused;
  assign bp_unused = ^update_pc[1:0];
`else
  assign predict_target = predict_taken ? tgt_q[l_idx] : seq_pc;

  logic bp_unused;
  assign bp_unused = ^{update_pc[1:0], lookup_fire} ^ (RAS_DEPTH == 0);
`endif

  // Update side
  logic [IDX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0] u_tag;
  logic                u_hit;

  assign u_idx = update_pc[IDX_BITS+1:2];
  assign u_tag = update_pc[31:IDX_BITS+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        tag_q[i]  <= '0;
        tgt_q[i]  <= '0;
        type_q[i] <= T_COND;
        ctr_q[i]  <= CTR_WNT;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (update_valid) begin
      if (u_hit) begin
        if (update_taken && ctr_q[u_idx] != CTR_MAX)
          ctr_q[u_idx] <= ctr_q[u_idx] + 1'b1;
        else if (!update_taken && ctr_q[u_idx] != '0)
          ctr_q[u_idx] <= ctr_q[u_idx] - 1'b1;
        if (update_taken) begin
          tgt_q[u_idx]  <= update_target;
          type_q[u_idx] <= update_type;
        end
      end else if (update_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= update_target;
        type_q[u_idx]  <= update_type;
        ctr_q[u_idx]   <= CTR_WT;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default 16 entries, 2-bit counters).
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        lookup_fire;
  logic        predict_hit, predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc, update_target;
  logic        update_taken;
  logic [1:0]  update_type;
  logic        flush;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .lookup_pc(lookup_pc), .lookup_fire(lookup_fire),
    .predict_hit(predict_hit), .predict_taken(predict_taken), .predict_target(predict_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
    .update_taken(update_taken), .update_type(update_type), .flush(flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    chk({tag, ".hit"}, {31'd0, predict_hit}, {31'd0, hit});
    chk({tag, ".taken"}, {31'd0, predict_taken}, {31'd0, tk});
    chk({tag, ".target"}, predict_target, tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                     input logic [1:0] ty);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_target = tgt;
    update_taken  = tk;
    update_type   = ty;
    @(posedge clk);
    #1;
    update_valid = 1'b0;
  endtask

  task automatic fire(input logic [31:0] pc);
    lookup_pc   = pc;
    lookup_fire = 1'b1;
    @(posedge clk);
    #1;
    lookup_fire = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; lookup_pc = 32'h40000000; lookup_fire = 1'b0;
    update_valid = 1'b0; update_pc = '0; update_target = '0;
    update_taken = 1'b0; update_type = 2'd0; flush = 1'b0;
    #2;
    look("in_reset", 32'h40000000, 0, 0, 32'h40000004);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    look("post_reset", 32'h40000000, 0, 0, 32'h40000004);

    // Same-cycle update is invisible until the next cycle
    lookup_pc = 32'h40000010;
    update_valid = 1'b1; update_pc = 32'h40000010; update_target = 32'h40000100;
    update_taken = 1'b1; update_type = 2'd0;
    #1;
    chk("no_bypass.hit", {31'd0, predict_hit}, 32'd0);
    @(posedge clk);
    #1 update_valid = 1'b0;
    look("alloc", 32'h40000010, 1, 1, 32'h40000100);

    // Counter walk: 2 -> 1 -> 0 -> 0, then up to saturation and back
    upd(32'h40000010, 32'h40000100, 0, 0);
    look("ctr1", 32'h40000010, 1, 0, 32'h40000014);
    upd(32'h40000010, 32'h40000100, 0, 0);
    look("ctr0", 32'h40000010, 1, 0, 32'h40000014);
    upd(32'h40000010, 32'h40000100, 0, 0);
    look("ctr0_sat", 32'h40000010, 1, 0, 32'h40000014);
    upd(32'h40000010, 32'h40000100, 1, 0);
    look("ctr_up1", 32'h40000010, 1, 0, 32'h40000014);
    upd(32'h40000010, 32'h40000100, 1, 0);
    look("ctr_up2", 32'h40000010, 1, 1, 32'h40000100);
    upd(32'h40000010, 32'h40000100, 1, 0);
    upd(32'h40000010, 32'h40000100, 1, 0);
    upd(32'h40000010, 32'h40000100, 0, 0);
    look("ctr3_sat_dn", 32'h40000010, 1, 1, 32'h40000100);
    upd(32'h40000010, 32'h40000100, 0, 0);
    look("ctr3_sat_dn2", 32'h40000010, 1, 0, 32'h40000014);

    // Index conflict, and a not-taken miss leaves the entry alone
    upd(32'h40000050, 32'h40000500, 1, 0);
    look("conflict_old", 32'h40000010, 0, 0, 32'h40000014);
    look("conflict_new", 32'h40000050, 1, 1, 32'h40000500);
    upd(32'h40000090, 32'h40000900, 0, 0);
    look("nt_miss_keep", 32'h40000050, 1, 1, 32'h40000500);
    look("nt_miss_none", 32'h40000090, 0, 0, 32'h40000094);

    // Jumps predict taken regardless of counter
    upd(32'h40000030, 32'h40000300, 1, 1);
    look("jump", 32'h40000030, 1, 1, 32'h40000300);
    upd(32'h40000030, 32'h40000300, 0, 1);
    look("jump_ctr_low", 32'h40000030, 1, 1, 32'h40000300);

    upd(32'h40000200, 32'h40000999, 1, 3);
`ifndef BP_RAS_EN
    look("ret_btb", 32'h40000200, 1, 1, 32'h40000999);
`else
    look("ret_empty", 32'h40000200, 1, 1, 32'h40000999);
    upd(32'h40000020, 32'h40000400, 1, 2);
    look("ret_nofire", 32'h40000200, 1, 1, 32'h40000999);
    fire(32'h40000020);
    look("ret_ras", 32'h40000200, 1, 1, 32'h40000024);
    fire(32'h40000200);
    look("ret_popped", 32'h40000200, 1, 1, 32'h40000999);
    for (int k = 0; k < 9; k++) begin
      upd(32'h40000020 + 32'(k) * 32'h40, 32'h40000400, 1, 2);
      fire(32'h40000020 + 32'(k) * 32'h40);
    end
    for (int k = 8; k >= 1; k--) begin
      look($sformatf("ras_pop%0d", k), 32'h40000200, 1, 1, 32'h40000024 + 32'(k) * 32'h40);
      fire(32'h40000200);
    end
    look("ras_empty", 32'h40000200, 1, 1, 32'h40000999);
    fire(32'h40000200);
    look("ras_empty2", 32'h40000200, 1, 1, 32'h40000999);
`endif

    // Flush beats a simultaneous update
    flush = 1'b1;
    upd(32'h40000060, 32'h40000600, 1, 0);
    flush = 1'b0;
    look("flush_a", 32'h40000050, 0, 0, 32'h40000054);
    look("flush_b", 32'h40000030, 0, 0, 32'h40000034);
    look("flush_upd", 32'h40000060, 0, 0, 32'h40000064);

    // Asynchronous reset, including one that lands on an update edge
    upd(32'h40000050, 32'h40000500, 1, 0);
    look("realloc", 32'h40000050, 1, 1, 32'h40000500);
    rst = 1'b0;
    look("async_rst", 32'h40000050, 0, 0, 32'h40000054);
    rst = 1'b1;
    @(posedge clk);
    #1;
    update_valid = 1'b1; update_pc = 32'h40000070; update_target = 32'h40000700;
    update_taken = 1'b1; update_type = 2'd0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    rst = 1'b1;
    look("rst_abort", 32'h40000070, 0, 0, 32'h40000074);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
